// File: rtl/uart_frame_check.sv
// UART frame validator: checks the MSGID header, runs a byte-serial CRC-8 over header+payload,
// publishes good payloads, counts bad/dropped frames, and flags loss of good traffic.
module uart_frame_check #(
    parameter int unsigned BUFFER_SIZE = 80,
    parameter logic [31:0] MSGID       = 32'h74697277,
    parameter logic [31:0] TIMEOUT     = 32'd1200000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [BUFFER_SIZE-1:0]  rx_data,
    input  logic                    sync,
    output logic [BUFFER_SIZE-41:0] payload,
    output logic                    valid,
    output logic                    error,
    output logic                    busy,
    output logic                    timeout,
    output logic [15:0]             err_id_count,
    output logic [15:0]             err_crc_count,
    output logic [15:0]             drop_count
);

    localparam int unsigned N_BYTES = BUFFER_SIZE / 8 - 1;
    localparam int          IDX_W   = $clog2(N_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CHECK = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]             state;
    logic [BUFFER_SIZE-33:0] frame_reg;   // payload + checksum; the header only feeds id_ok
    logic [BUFFER_SIZE-1:0] shift_reg;
    logic                   id_ok;
    logic [7:0]             crc;
    logic [IDX_W-1:0]       byte_idx;
    logic [31:0]            wd_cnt;
    logic [31:0]            wd_next;
    logic                   good_frame;

    // One CRC-8 byte step (poly 0x07, MSB-first), unrolled over 8 bit-steps.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc_in, input logic [7:0] data);
        logic [7:0] c;
        c = crc_in ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    assign busy       = (state != IDLE);
    assign good_frame = (state == DONE) && id_ok && (crc == frame_reg[7:0]);

    // NOTE: every variable assigned in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        wd_next = wd_cnt;
        if (wd_cnt < TIMEOUT) wd_next = wd_cnt + 32'd1;
    end

    // NOTE: pure datapath registers carry no reset; they are always loaded before they are read.
    always_ff @(posedge clk) begin
        if (state == IDLE && sync) begin
            frame_reg <= rx_data[BUFFER_SIZE-33:0];
            shift_reg <= rx_data;
            id_ok     <= (rx_data[BUFFER_SIZE-1 -: 32] == MSGID);
        end else if (state == CHECK) begin
            shift_reg <= shift_reg << 8;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            crc           <= 8'h00;
            byte_idx      <= '0;
            payload       <= '0;
            valid         <= 1'b0;
            error         <= 1'b0;
            timeout       <= 1'b0;
            wd_cnt        <= 32'd0;
            err_id_count  <= 16'd0;
            err_crc_count <= 16'd0;
            drop_count    <= 16'd0;
        end else begin
            valid <= 1'b0;
            error <= 1'b0;

            case (state)
                IDLE: begin
                    if (sync) begin
                        crc      <= 8'h00;
                        byte_idx <= '0;
                        state    <= CHECK;
                    end
                end
                CHECK: begin
                    crc      <= crc8_step(crc, shift_reg[BUFFER_SIZE-1 -: 8]);
                    byte_idx <= byte_idx + 1'b1;
                    if (byte_idx == LAST_IDX) state <= DONE;
                end
                DONE: begin
                    if (!id_ok) begin
                        error <= 1'b1;
                        if (err_id_count != 16'hFFFF) err_id_count <= err_id_count + 16'd1;
                    end else if (crc != frame_reg[7:0]) begin
                        error <= 1'b1;
                        if (err_crc_count != 16'hFFFF) err_crc_count <= err_crc_count + 16'd1;
                    end else begin
                        payload <= frame_reg[BUFFER_SIZE-33:8];
                        valid   <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // A strobe arriving while a check is running (including the DONE cycle) is lost.
            if (sync && state != IDLE && drop_count != 16'hFFFF)
                drop_count <= drop_count + 16'd1;

            if (good_frame) begin
                wd_cnt  <= 32'd0;
                timeout <= 1'b0;
            end else begin
                wd_cnt  <= wd_next;
                timeout <= (wd_next == TIMEOUT);
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_check.sv
// Directed bench for uart_frame_check: good/bad frames, overrun drops, watchdog and mid-check reset.
module tb_uart_frame_check;

    localparam int unsigned BS = 80;
    localparam logic [BS-1:0] GOOD    = 80'h31323334_3536373839_F4;
    localparam logic [BS-1:0] BAD_CRC = 80'h31323334_3536373839_F5;
    localparam logic [BS-1:0] BAD_ID  = 80'h31323335_3536373839_F4;
    localparam logic [BS-1:0] OTHER   = 80'h31323334_4142434445_00;
    localparam logic [39:0]   PAY     = 40'h3536373839;

    logic          clk = 1'b0;
    logic          rst;
    logic [BS-1:0] rx_data;
    logic          sync;
    logic [39:0]   payload;
    logic          valid, error, busy, timeout;
    logic [15:0]   err_id_count, err_crc_count, drop_count;

    int n_cmp  = 0;
    int n_fail = 0;

    uart_frame_check #(
        .BUFFER_SIZE(BS),
        .MSGID      (32'h31323334),
        .TIMEOUT    (32'd100)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .sync         (sync),
        .payload      (payload),
        .valid        (valid),
        .error        (error),
        .busy         (busy),
        .timeout      (timeout),
        .err_id_count (err_id_count),
        .err_crc_count(err_crc_count),
        .drop_count   (drop_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents a frame for the E0 edge and releases the strobe afterwards.
    task automatic send(input logic [BS-1:0] frame);
        rx_data = frame;
        sync    = 1'b1;
        tick();
        sync    = 1'b0;
        rx_data = '0;
    endtask

    task automatic check_counts(input string tag, input logic [15:0] id_e,
                                input logic [15:0] crc_e, input logic [15:0] drop_e);
        check({tag, "_err_id"},  64'(err_id_count),  64'(id_e));
        check({tag, "_err_crc"}, 64'(err_crc_count), 64'(crc_e));
        check({tag, "_drop"},    64'(drop_count),    64'(drop_e));
    endtask

    initial begin
        rst     = 1'b1;
        sync    = 1'b0;
        rx_data = '0;
        repeat (3) tick();

        // Reset state
        check("rst_valid",   64'(valid),   64'(0));
        check("rst_error",   64'(error),   64'(0));
        check("rst_busy",    64'(busy),    64'(0));
        check("rst_timeout", 64'(timeout), 64'(0));
        check("rst_payload", 64'(payload), 64'(0));
        check_counts("rst", 16'd0, 16'd0, 16'd0);

        // Watchdog expires exactly 100 edges after reset release
        rst = 1'b0;
        repeat (99) tick();
        check("wd_before", 64'(timeout), 64'(0));
        tick();
        check("wd_rise", 64'(timeout), 64'(1));

        // Good frame: valid at E10, watchdog cleared on that edge
        send(GOOD);
        check("good_busy_e0", 64'(busy), 64'(1));
        repeat (9) tick();
        check("good_valid_e9", 64'(valid),   64'(0));
        check("good_busy_e9",  64'(busy),    64'(1));
        check("good_wd_e9",    64'(timeout), 64'(1));
        tick();
        check("good_valid",   64'(valid),   64'(1));
        check("good_error",   64'(error),   64'(0));
        check("good_payload", 64'(payload), 64'(PAY));
        check("good_busy",    64'(busy),    64'(0));
        check("good_wd_clr",  64'(timeout), 64'(0));
        check_counts("good", 16'd0, 16'd0, 16'd0);
        tick();
        check("good_valid_pulse", 64'(valid), 64'(0));
        repeat (98) tick();
        check("wd2_before", 64'(timeout), 64'(0));
        tick();
        check("wd2_rise", 64'(timeout), 64'(1));

        // Bad checksum
        send(BAD_CRC);
        repeat (9) tick();
        check("crc_error_e9", 64'(error), 64'(0));
        tick();
        check("crc_error",   64'(error),   64'(1));
        check("crc_valid",   64'(valid),   64'(0));
        check("crc_payload", 64'(payload), 64'(PAY));
        check("crc_wd_held", 64'(timeout), 64'(1));
        check_counts("crc", 16'd0, 16'd1, 16'd0);

        // Bad header, strobed at E11 of the previous frame (earliest acceptance)
        send(BAD_ID);
        check("id_busy_e0",    64'(busy),  64'(1));
        check("crc_error_pulse", 64'(error), 64'(0));
        repeat (9) tick();
        tick();
        check("id_error", 64'(error), 64'(1));
        check("id_valid", 64'(valid), 64'(0));
        check_counts("id", 16'd1, 16'd1, 16'd0);
        tick();

        // Overrun: second strobe 3 clocks in, third strobe on the DONE edge
        send(GOOD);
        tick();
        tick();
        rx_data = OTHER;
        sync    = 1'b1;
        tick();
        sync    = 1'b0;
        check("ovr_drop1", 64'(drop_count), 64'(1));
        repeat (6) tick();
        check("ovr_valid_e9", 64'(valid), 64'(0));
        rx_data = OTHER;
        sync    = 1'b1;
        tick();
        sync    = 1'b0;
        check("ovr_valid",   64'(valid),   64'(1));
        check("ovr_payload", 64'(payload), 64'(PAY));
        check_counts("ovr", 16'd1, 16'd1, 16'd2);
        tick();
        check("ovr_done_drop_idle", 64'(busy), 64'(0));

        // Reset four clocks into a check aborts it
        send(GOOD);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_busy",    64'(busy),    64'(0));
        check("mid_valid",   64'(valid),   64'(0));
        check("mid_error",   64'(error),   64'(0));
        check("mid_payload", 64'(payload), 64'(0));
        check_counts("mid", 16'd0, 16'd0, 16'd0);
        repeat (8) tick();
        check("mid_no_valid", 64'(valid), 64'(0));
        check("mid_no_error", 64'(error), 64'(0));

        send(GOOD);
        repeat (10) tick();
        check("post_valid",   64'(valid),   64'(1));
        check("post_payload", 64'(payload), 64'(PAY));
        check_counts("post", 16'd0, 16'd0, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
